// File: rtl/branch_predict_unit.sv
// rtl/branch_predict_unit.sv - direct-mapped BTB with 2-bit counters, branch resolve and redirect
// Optional macro BRANCH_PERF_EN adds control-flow and mispredict counters.
module branch_predict_unit #(
  parameter int         PC_W      = 9,
  parameter int         BTB_DEPTH = 16,
  parameter int         IDX_W     = $clog2(BTB_DEPTH),
  parameter logic [1:0] CTR_INIT  = 2'b01
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [PC_W-1:0] F_PC,
  output logic            F_PredTaken,
  output logic [31:0]     F_PredPC,
  input  logic            E_Valid,
  input  logic [PC_W-1:0] E_PC,
  input  logic [31:0]     E_Imm,
  input  logic            E_Branch,
  input  logic            E_Jump,
  input  logic            E_JumpReg,
  input  logic            E_Halt,
  input  logic [31:0]     E_AluResult,
  input  logic            E_PredTaken,
  input  logic [31:0]     E_PredPC,
  output logic [31:0]     PC_Imm,
  output logic [31:0]     PC_Four,
  output logic [31:0]     BrPC,
  output logic            PcSel,
  output logic            Flush
`ifdef BRANCH_PERF_EN
  ,
  output logic [31:0]     Perf_CfCount,
  output logic [31:0]     Perf_MissCount
`endif
);

  localparam int TAG_W = PC_W - IDX_W - 2;

  logic             valid_q  [BTB_DEPTH];
  logic [TAG_W-1:0] tag_q    [BTB_DEPTH];
  logic [1:0]       ctr_q    [BTB_DEPTH];
  logic [PC_W-1:0]  target_q [BTB_DEPTH];

  logic [IDX_W-1:0] f_idx, e_idx;
  logic [TAG_W-1:0] f_tag, e_tag;
  logic             f_hit, e_hit;
  logic             cf, taken, mispredict, is_alias;
  logic [31:0]      pc_imm_raw, pc_four_raw;

  assign f_idx = F_PC[IDX_W+1:2];
  assign f_tag = F_PC[PC_W-1:IDX_W+2];
  assign e_idx = E_PC[IDX_W+1:2];
  assign e_tag = E_PC[PC_W-1:IDX_W+2];

  assign f_hit       = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
  assign F_PredTaken = f_hit && ctr_q[f_idx][1];
  assign F_PredPC    = F_PredTaken ? 32'(target_q[f_idx]) : 32'(F_PC) + 32'd4;

  assign e_hit       = valid_q[e_idx] && (tag_q[e_idx] == e_tag);
  assign pc_imm_raw  = E_JumpReg ? E_AluResult : 32'(E_PC) + E_Imm;
  assign pc_four_raw = 32'(E_PC) + 32'd4;
  assign cf          = E_Branch | E_Jump | E_JumpReg;
  assign taken       = (E_Branch & E_AluResult[0]) | E_Jump | E_JumpReg;
  assign mispredict  = E_Valid & ((taken != E_PredTaken) | (taken & (pc_imm_raw != E_PredPC)));
  // A taken prediction on a non-branch means the BTB entry aliased onto this PC.
  assign is_alias    = !cf && E_PredTaken;

  assign PC_Imm  = E_Valid ? pc_imm_raw : 32'd0;
  assign PC_Four = E_Valid ? pc_four_raw : 32'd0;
  assign Flush   = mispredict;
  assign PcSel   = mispredict | (E_Valid & E_Halt);

  always_comb begin
    BrPC = 32'd0;
    if (mispredict)
      BrPC = taken ? pc_imm_raw : pc_four_raw;
    else if (E_Valid && E_Halt)
      BrPC = 32'(E_PC);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < BTB_DEPTH; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= CTR_INIT;
      end
    end else if (E_Valid) begin
      if (taken) begin
        valid_q[e_idx]  <= 1'b1;
        tag_q[e_idx]    <= e_tag;
        target_q[e_idx] <= pc_imm_raw[PC_W-1:0];
        if (E_Jump || E_JumpReg)
          ctr_q[e_idx] <= 2'b11;
        else if (e_hit)
          ctr_q[e_idx] <= (ctr_q[e_idx] == 2'b11) ? 2'b11 : ctr_q[e_idx] + 2'd1;
        else
          ctr_q[e_idx] <= 2'b10;
      end else if (E_Branch) begin
        // Not-taken branches only train an existing entry, never allocate.
        if (e_hit)
          ctr_q[e_idx] <= (ctr_q[e_idx] == 2'b00) ? 2'b00 : ctr_q[e_idx] - 2'd1;
      end else if (is_alias && e_hit) begin
        valid_q[e_idx] <= 1'b0;
      end
    end
  end

`ifdef BRANCH_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      Perf_CfCount   <= 32'd0;
      Perf_MissCount <= 32'd0;
    end else begin
      if (E_Valid && cf)
        Perf_CfCount <= Perf_CfCount + 32'd1;
      if (mispredict)
        Perf_MissCount <= Perf_MissCount + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// tb/tb_branch_predict_unit.sv - randomized bench with behavioural BTB model for branch_predict_unit
// Directed scenarios pin the model; BRANCH_PERF_EN also checks the perf counters.
module tb_branch_predict_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [8:0]  F_PC;
  logic        F_PredTaken;
  logic [31:0] F_PredPC;
  logic        E_Valid;
  logic [8:0]  E_PC;
  logic [31:0] E_Imm;
  logic        E_Branch, E_Jump, E_JumpReg, E_Halt;
  logic [31:0] E_AluResult;
  logic        E_PredTaken;
  logic [31:0] E_PredPC;
  logic [31:0] PC_Imm, PC_Four, BrPC;
  logic        PcSel, Flush;
`ifdef BRANCH_PERF_EN
  logic [31:0] perf_cf, perf_miss;
`endif

  branch_predict_unit dut (
    .clk(clk), .reset(reset), .F_PC(F_PC), .F_PredTaken(F_PredTaken), .F_PredPC(F_PredPC),
    .E_Valid(E_Valid), .E_PC(E_PC), .E_Imm(E_Imm), .E_Branch(E_Branch), .E_Jump(E_Jump),
    .E_JumpReg(E_JumpReg), .E_Halt(E_Halt), .E_AluResult(E_AluResult),
    .E_PredTaken(E_PredTaken), .E_PredPC(E_PredPC), .PC_Imm(PC_Imm), .PC_Four(PC_Four),
    .BrPC(BrPC), .PcSel(PcSel), .Flush(Flush)
`ifdef BRANCH_PERF_EN
    , .Perf_CfCount(perf_cf), .Perf_MissCount(perf_miss)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: 16 entries, index = (pc/4) mod 16, tag = pc/64.
  bit          m_valid [16];
  int          m_tag   [16];
  int          m_ctr   [16];
  int          m_tgt   [16];
  bit          started = 0;
  longint      m_cf = 0, m_miss = 0;

  function automatic int ix(input logic [8:0] pc);
    return (int'(pc) / 4) % 16;
  endfunction

  function automatic bit m_hit(input logic [8:0] pc);
    return m_valid[ix(pc)] && (m_tag[ix(pc)] == int'(pc) / 64);
  endfunction

  function automatic bit m_pt(input logic [8:0] pc);
    return m_hit(pc) && (m_ctr[ix(pc)] >= 2);
  endfunction

  function automatic logic [31:0] m_ppc(input logic [8:0] pc);
    return m_pt(pc) ? 32'(m_tgt[ix(pc)]) : 32'(int'(pc) + 4);
  endfunction

  function automatic void resolve(output bit cf, output bit tk, output logic [31:0] tgt,
                                  output bit mis);
    cf  = E_Branch || E_Jump || E_JumpReg;
    tk  = (E_Branch && E_AluResult[0]) || E_Jump || E_JumpReg;
    tgt = E_JumpReg ? E_AluResult : 32'(longint'(E_PC) + longint'(E_Imm));
    mis = E_Valid && ((tk != E_PredTaken) || (tk && tgt != E_PredPC));
  endfunction

  always @(posedge clk) begin : model_update
    bit cf, tk, mis, hit;
    logic [31:0] tgt;
    int i;
    if (reset) begin
      for (int k = 0; k < 16; k++) begin
        m_valid[k] = 0;
        m_ctr[k]   = 1;
      end
      m_cf = 0;
      m_miss = 0;
      started = 1;
    end else if (E_Valid) begin
      resolve(cf, tk, tgt, mis);
      i   = ix(E_PC);
      hit = m_hit(E_PC);
      if (cf) m_cf = (m_cf + 1) % 64'h1_0000_0000;
      if (mis) m_miss = (m_miss + 1) % 64'h1_0000_0000;
      if (tk) begin
        if (E_Jump || E_JumpReg) m_ctr[i] = 3;
        else if (hit) m_ctr[i] = (m_ctr[i] + 1 > 3) ? 3 : m_ctr[i] + 1;
        else m_ctr[i] = 2;
        m_valid[i] = 1;
        m_tag[i]   = int'(E_PC) / 64;
        m_tgt[i]   = int'(tgt % 512);
      end else if (E_Branch) begin
        if (hit) m_ctr[i] = (m_ctr[i] - 1 < 0) ? 0 : m_ctr[i] - 1;
      end else if (E_PredTaken && hit) begin
        m_valid[i] = 0;
      end
    end
  end

  always @(negedge clk) begin : compare
    bit cf, tk, mis;
    logic [31:0] tgt, exp_br;
    if (started) begin
      chk("pred_taken", F_PredTaken, m_pt(F_PC));
      chk("pred_pc", F_PredPC, m_ppc(F_PC));
      resolve(cf, tk, tgt, mis);
      exp_br = mis ? (tk ? tgt : 32'(E_PC) + 32'd4) : (E_Valid && E_Halt) ? 32'(E_PC) : 32'd0;
      chk("pc_imm", PC_Imm, E_Valid ? tgt : 32'd0);
      chk("pc_four", PC_Four, E_Valid ? 32'(E_PC) + 32'd4 : 32'd0);
      chk("flush", Flush, mis);
      chk("pcsel", PcSel, mis || (E_Valid && E_Halt));
      chk("brpc", BrPC, exp_br);
`ifdef BRANCH_PERF_EN
      chk("perf_cf", perf_cf, 32'(m_cf));
      chk("perf_miss", perf_miss, 32'(m_miss));
`endif
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    E_Valid = 0; E_PC = '0; E_Imm = '0; E_Branch = 0; E_Jump = 0; E_JumpReg = 0;
    E_Halt = 0; E_AluResult = '0; E_PredTaken = 0; E_PredPC = '0;
  endtask

  task automatic set_e(input logic [8:0] pc, input logic [31:0] imm, input bit br, input bit j,
                       input bit jr, input bit halt, input logic [31:0] alu, input bit pt,
                       input logic [31:0] ppc);
    E_Valid = 1; E_PC = pc; E_Imm = imm; E_Branch = br; E_Jump = j; E_JumpReg = jr;
    E_Halt = halt; E_AluResult = alu; E_PredTaken = pt; E_PredPC = ppc;
  endtask

  function automatic logic [8:0] rpc();
    if ($urandom_range(0, 3) == 0) return 9'($urandom_range(0, 511));
    return 9'(($urandom_range(0, 7) << 6) | ($urandom_range(0, 3) << 2));
  endfunction

  task automatic rand_cycle;
    int ty;
    tick;
    reset   = ($urandom_range(0, 99) < 2);
    F_PC    = rpc();
    E_Valid = ($urandom_range(0, 9) != 0);
    E_PC    = rpc();
    E_Imm   = 32'($urandom_range(0, 255)) - 32'd128;
    ty      = $urandom_range(0, 5);
    E_Branch = (ty == 1); E_Jump = (ty == 2); E_JumpReg = (ty == 3); E_Halt = (ty == 4);
    E_AluResult = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 511)) : 32'($urandom);
    if ($urandom_range(0, 1) != 0) begin
      E_PredTaken = m_pt(E_PC);
      E_PredPC    = m_ppc(E_PC);
    end else begin
      E_PredTaken = ($urandom_range(0, 1) != 0);
      E_PredPC    = ($urandom_range(0, 1) != 0) ? 32'(E_PC) + E_Imm : 32'($urandom_range(0, 511));
    end
  endtask

  initial begin
    reset = 1; F_PC = '0; idle();
    tick; tick;
    reset = 0; F_PC = 9'h040;
    @(negedge clk);
    chk("rst_pt", F_PredTaken, 0);
    chk("rst_ppc", F_PredPC, 32'h44);
    for (int i = 0; i < 16; i++) begin
      tick; F_PC = 9'(i * 4);
      @(negedge clk);
      chk("rst_sweep_pt", F_PredTaken, 0);
      chk("rst_sweep_ppc", F_PredPC, 32'(i * 4 + 4));
    end

    tick; F_PC = 9'h040; set_e(9'h040, 32'h20, 1, 0, 0, 0, 32'h1, 0, 32'h44);
    @(negedge clk);
    chk("br1_flush", Flush, 1); chk("br1_pcsel", PcSel, 1); chk("br1_brpc", BrPC, 32'h60);
    chk("rdw_pt", F_PredTaken, 0);
    tick; idle(); F_PC = 9'h040;
    @(negedge clk);
    chk("br1_lookup_pt", F_PredTaken, 1); chk("br1_lookup_ppc", F_PredPC, 32'h60);

    tick; set_e(9'h040, 32'h20, 1, 0, 0, 0, 32'h1, 1, 32'h60);
    @(negedge clk);
    chk("br2_flush", Flush, 0); chk("br2_pcsel", PcSel, 0);
    tick; set_e(9'h040, 32'h20, 1, 0, 0, 0, 32'h0, 1, 32'h60);
    @(negedge clk);
    chk("nt1_flush", Flush, 1); chk("nt1_brpc", BrPC, 32'h44);
    tick; set_e(9'h040, 32'h20, 1, 0, 0, 0, 32'h0, 1, 32'h60);
    @(negedge clk);
    chk("nt2_flush", Flush, 1);
    tick; F_PC = 9'h040; set_e(9'h040, 32'h20, 1, 0, 0, 0, 32'h0, 0, 32'h44);
    @(negedge clk);
    chk("nt3_flush", Flush, 0); chk("ctr01_pt", F_PredTaken, 0); chk("ctr01_ppc", F_PredPC, 32'h44);

    tick; set_e(9'h040, 32'h20, 0, 1, 0, 0, 32'h0, 0, 32'h44);
    @(negedge clk);
    chk("jal_brpc", BrPC, 32'h60);
    tick; idle(); F_PC = 9'h040;
    @(negedge clk);
    chk("jal_lookup_pt", F_PredTaken, 1);
    tick; set_e(9'h040, 32'h0, 0, 0, 0, 0, 32'h0, 1, 32'h60);
    @(negedge clk);
    chk("alias_flush", Flush, 1); chk("alias_brpc", BrPC, 32'h44);
    tick; idle(); F_PC = 9'h040;
    @(negedge clk);
    chk("alias_inval_pt", F_PredTaken, 0); chk("alias_inval_ppc", F_PredPC, 32'h44);

    tick; set_e(9'h080, 32'h80, 0, 1, 0, 0, 32'h0, 0, 32'h84);
    @(negedge clk);
    chk("jal80_brpc", BrPC, 32'h100);
    tick; set_e(9'h080, 32'h0, 0, 0, 1, 0, 32'h1F4, 1, 32'h100);
    @(negedge clk);
    chk("jalr_flush", Flush, 1); chk("jalr_brpc", BrPC, 32'h1F4);
    tick; idle(); F_PC = 9'h080;
    @(negedge clk);
    chk("jalr_lookup_pt", F_PredTaken, 1); chk("jalr_lookup_ppc", F_PredPC, 32'h1F4);

    tick; set_e(9'h0C0, 32'h0, 0, 0, 0, 1, 32'h0, 0, 32'hC4);
    @(negedge clk);
    chk("halt_pcsel", PcSel, 1); chk("halt_flush", Flush, 0); chk("halt_brpc", BrPC, 32'hC0);
    tick; set_e(9'h0C0, 32'h0, 0, 0, 0, 1, 32'h0, 1, 32'h200);
    @(negedge clk);
    chk("halt_mis_flush", Flush, 1); chk("halt_mis_brpc", BrPC, 32'hC4);

    tick; reset = 1; set_e(9'h100, 32'h40, 0, 1, 0, 0, 32'h0, 0, 32'h104);
    tick; reset = 0; idle(); F_PC = 9'h100;
    @(negedge clk);
    chk("rst_wins_pt", F_PredTaken, 0); chk("rst_wins_ppc", F_PredPC, 32'h104);
`ifdef BRANCH_PERF_EN
    chk("rst_perf_cf", perf_cf, 0); chk("rst_perf_miss", perf_miss, 0);
`endif
    tick; F_PC = 9'h080;
    @(negedge clk);
    chk("rst_cleared_pt", F_PredTaken, 0);

    for (int n = 0; n < 3000; n++) rand_cycle();
    tick; reset = 0; idle();
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
